// File: rtl/des_pkg.sv
// Shared constants, types and rotate helpers for the DES key-schedule engine.
package des_pkg;

  typedef logic [27:0] half_t;
  typedef logic [47:0] subkey_t;

  typedef enum logic {IDLE, RUN} ks_state_t;

  localparam logic [1:0] SHIFT_TABLE [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // FIPS 1-based bit numbers into the 56-bit C||D word, in subkey order.
  localparam int PC2_TABLE [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic half_t rotl(input half_t x, input logic [1:0] n);
    half_t r;
    case (n)
      2'd1:    r = {x[26:0], x[27]};
      2'd2:    r = {x[25:0], x[27:26]};
      default: r = x;
    endcase
    return r;
  endfunction

  function automatic half_t rotr(input half_t x, input logic [1:0] n);
    half_t r;
    case (n)
      2'd1:    r = {x[0], x[27:1]};
      2'd2:    r = {x[1:0], x[27:2]};
      default: r = x;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pc2.sv
// Purely combinational PC-2 selection: 56-bit C||D (bit 55 = FIPS bit 1) to 48-bit subkey.
module pc2
  import des_pkg::*;
(
  input  logic [55:0] cd_i,
  output subkey_t     subkey_o
);

  // FIPS bit n of the input lives at cd_i[56-n]; subkey bit j at subkey_o[48-j].
  for (genvar j = 0; j < 48; j++) begin : g_sel
    assign subkey_o[47-j] = cd_i[56-PC2_TABLE[j]];
  end

endmodule

// File: rtl/des_key_schedule.sv
// DES key schedule: rotates C/D halves per round and emits 16 PC-2 subkeys over valid/ready.
// Optional decrypt ordering (K16..K1) is enabled by defining DES_KEY_DECRYPT_EN.
module des_key_schedule
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [27:0] c_in,
  input  logic [27:0] d_in,
  output logic        key_valid,
  input  logic        key_ready,
  output logic [47:0] subkey,
  output logic [3:0]  round,
  output logic        last
`ifdef DES_KEY_DECRYPT_EN
  ,
  input  logic        decrypt
`endif
);

  ks_state_t  state_q, state_d;
  half_t      c_q, c_d;
  half_t      d_q, d_d;
  logic [3:0] round_q, round_d;
  logic       mode_dec;

`ifdef DES_KEY_DECRYPT_EN
  logic decMode_q, decMode_d;
  assign mode_dec = decMode_q;
`else
  assign mode_dec = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      round_q <= round_d;
    end
  end

`ifdef DES_KEY_DECRYPT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) decMode_q <= 1'b0;
    else     decMode_q <= decMode_d;
  end

  always_comb begin
    decMode_d = decMode_q;
    if (state_q == IDLE && load_valid) decMode_d = decrypt;
  end
`endif

  // Decrypt walks the rotations backwards: C16 == C0, then right-rotate by the mirrored table entry.
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    round_d = round_q;
    case (state_q)
      IDLE: begin
        if (load_valid) begin
          state_d = RUN;
          round_d = 4'd0;
`ifdef DES_KEY_DECRYPT_EN
          if (decrypt) begin
            c_d = c_in;
            d_d = d_in;
          end else begin
            c_d = rotl(c_in, SHIFT_TABLE[0]);
            d_d = rotl(d_in, SHIFT_TABLE[0]);
          end
`else
          c_d = rotl(c_in, SHIFT_TABLE[0]);
          d_d = rotl(d_in, SHIFT_TABLE[0]);
`endif
        end
      end
      RUN: begin
        if (key_ready) begin
          if (round_q == 4'd15) begin
            state_d = IDLE;
            round_d = 4'd0;
          end else begin
            round_d = round_q + 4'd1;
            if (mode_dec) begin
              c_d = rotr(c_q, SHIFT_TABLE[4'd15 - round_q]);
              d_d = rotr(d_q, SHIFT_TABLE[4'd15 - round_q]);
            end else begin
              c_d = rotl(c_q, SHIFT_TABLE[round_q + 4'd1]);
              d_d = rotl(d_q, SHIFT_TABLE[round_q + 4'd1]);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  pc2 u_pc2 (
    .cd_i     ({c_q, d_q}),
    .subkey_o (subkey)
  );

  assign load_ready = (state_q == IDLE);
  assign key_valid  = (state_q == RUN);
  assign round      = round_q;
  assign last       = key_valid && (round_q == 4'd15);

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule against a bit-level FIPS key-schedule model.
module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid;
  logic        load_ready;
  logic [27:0] c_in;
  logic [27:0] d_in;
  logic        key_valid;
  logic        key_ready;
  logic [47:0] subkey;
  logic [3:0]  round;
  logic        last;
`ifdef DES_KEY_DECRYPT_EN
  logic        decrypt;
`endif

  int checkCount = 0;
  int errorCount = 0;

  des_key_schedule dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .c_in       (c_in),
    .d_in       (d_in),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .subkey     (subkey),
    .round      (round),
    .last       (last)
`ifdef DES_KEY_DECRYPT_EN
    ,
    .decrypt    (decrypt)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [27:0] FIPS_C = 28'hF0CCAAF;
  localparam logic [27:0] FIPS_D = 28'h556678F;

  int shiftTab [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  int pc2Tab [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // Ki from C0/D0 using the cumulative rotation amount and FIPS bit numbering.
  function automatic logic [47:0] refSubkey(input logic [27:0] c0, input logic [27:0] d0, input int n);
    int          cum;
    int          src;
    logic [55:0] cd;
    logic [47:0] k;
    cum = 0;
    for (int r = 0; r <= n; r++) cum += shiftTab[r];
    for (int b = 1; b <= 28; b++) begin
      src = (b - 1 + cum) % 28;
      cd[56-b] = c0[27-src];
      cd[28-b] = d0[27-src];
    end
    for (int j = 1; j <= 48; j++) k[48-j] = cd[56-pc2Tab[j-1]];
    return k;
  endfunction

  task automatic checkOutput(input string tag, input logic [47:0] observed, input logic [47:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Loads one key and drains its 16 subkeys with random backpressure, checking every presented key.
  task automatic applyStimulus(input logic [27:0] c0, input logic [27:0] d0, input bit dec,
                               input int readyPct, output logic [47:0] firstKey,
                               output logic [47:0] secondKey, output logic [47:0] lastKey);
    int idx;
    int cycles;
    int k;
    firstKey  = '0;
    secondKey = '0;
    lastKey   = '0;
    c_in = c0;
    d_in = d0;
`ifdef DES_KEY_DECRYPT_EN
    decrypt = dec;
`endif
    load_valid = 1'b1;
    key_ready  = 1'b0;
    checkOutput("load_ready_idle", {47'd0, load_ready}, 48'd1);
    stepCycle();
    load_valid = 1'b0;
    c_in = 28'($urandom);
    d_in = 28'($urandom);
    idx = 0;
    cycles = 0;
    while (idx < 16 && cycles < 400) begin
      key_ready = ($urandom_range(0, 99) < readyPct);
      k = dec ? 15 - idx : idx;
      checkOutput("key_valid", {47'd0, key_valid}, 48'd1);
      checkOutput("round", {44'd0, round}, 48'(idx));
      checkOutput("subkey", subkey, refSubkey(c0, d0, k));
      checkOutput("last", {47'd0, last}, {47'd0, idx == 15});
      if (key_ready) begin
        if (idx == 0)  firstKey  = subkey;
        if (idx == 1)  secondKey = subkey;
        if (idx == 15) lastKey   = subkey;
        idx++;
      end
      stepCycle();
      cycles++;
    end
    if (idx < 16) checkOutput("drain_timeout", 48'(idx), 48'd16);
    key_ready = 1'b0;
    checkOutput("idle_key_valid", {47'd0, key_valid}, 48'd0);
    checkOutput("idle_load_ready", {47'd0, load_ready}, 48'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [47:0] k1, k2, kl;
    logic [27:0] c2, d2;

    rst = 1'b1;
    load_valid = 1'b0;
    key_ready = 1'b0;
    c_in = '0;
    d_in = '0;
`ifdef DES_KEY_DECRYPT_EN
    decrypt = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_key_valid", {47'd0, key_valid}, 48'd0);
    checkOutput("rst_load_ready", {47'd0, load_ready}, 48'd1);
    checkOutput("rst_last", {47'd0, last}, 48'd0);
    checkOutput("rst_round", {44'd0, round}, 48'd0);
    checkOutput("rst_subkey", subkey, 48'd0);
    rst = 1'b0;
    stepCycle();

    // FIPS vector, key_ready tied high: 16 consecutive cycles.
    applyStimulus(FIPS_C, FIPS_D, 1'b0, 100, k1, k2, kl);
    checkOutput("fips_k1", k1, 48'h1B02EFFC7072);
    checkOutput("fips_k2", k2, 48'h79AED9DBC9E5);
    checkOutput("fips_k16", kl, 48'hCB3D8B0E17F5);

    // Backpressure at round 3 and an ignored load at round 7.
    c_in = FIPS_C;
    d_in = FIPS_D;
    load_valid = 1'b1;
    key_ready = 1'b1;
    stepCycle();
    load_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      load_valid = 1'b0;
      if (i == 3) begin
        key_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          stepCycle();
          checkOutput("stall_round", {44'd0, round}, 48'd3);
          checkOutput("stall_subkey", subkey, refSubkey(FIPS_C, FIPS_D, 3));
          checkOutput("stall_valid", {47'd0, key_valid}, 48'd1);
        end
        key_ready = 1'b1;
      end
      if (i == 7) begin
        load_valid = 1'b1;
        c_in = 28'h1234567;
        d_in = 28'h89ABCDE;
        checkOutput("run_load_ready", {47'd0, load_ready}, 48'd0);
      end
      checkOutput("bp_round", {44'd0, round}, 48'(i));
      checkOutput("bp_subkey", subkey, refSubkey(FIPS_C, FIPS_D, i));
      checkOutput("bp_last", {47'd0, last}, {47'd0, i == 15});
      stepCycle();
    end
    load_valid = 1'b0;
    key_ready = 1'b0;
    checkOutput("bp_done_ready", {47'd0, load_ready}, 48'd1);

    // Asynchronous reset in the middle of round 9.
    c_in = FIPS_C;
    d_in = FIPS_D;
    load_valid = 1'b1;
    key_ready = 1'b1;
    stepCycle();
    load_valid = 1'b0;
    repeat (9) stepCycle();
    checkOutput("pre_rst_round", {44'd0, round}, 48'd9);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_key_valid", {47'd0, key_valid}, 48'd0);
    checkOutput("async_load_ready", {47'd0, load_ready}, 48'd1);
    checkOutput("async_subkey", subkey, 48'd0);
    rst = 1'b0;
    applyStimulus(FIPS_C, FIPS_D, 1'b0, 100, k1, k2, kl);
    checkOutput("restart_k1", k1, 48'h1B02EFFC7072);

    // Back-to-back loads with load_valid held high.
    c2 = 28'($urandom);
    d2 = 28'($urandom);
    c_in = FIPS_C;
    d_in = FIPS_D;
    load_valid = 1'b1;
    key_ready = 1'b1;
    stepCycle();
    c_in = c2;
    d_in = d2;
    for (int i = 0; i < 16; i++) begin
      checkOutput("b2b_subkey", subkey, refSubkey(FIPS_C, FIPS_D, i));
      stepCycle();
    end
    checkOutput("b2b_gap_valid", {47'd0, key_valid}, 48'd0);
    checkOutput("b2b_gap_ready", {47'd0, load_ready}, 48'd1);
    stepCycle();
    load_valid = 1'b0;
    checkOutput("b2b_second_valid", {47'd0, key_valid}, 48'd1);
    checkOutput("b2b_second_round", {44'd0, round}, 48'd0);
    checkOutput("b2b_second_k1", subkey, refSubkey(c2, d2, 0));
    repeat (16) stepCycle();
    key_ready = 1'b0;
    checkOutput("b2b_done_ready", {47'd0, load_ready}, 48'd1);

    // Random keys under random backpressure.
    for (int t = 0; t < 6; t++) begin
      applyStimulus(28'($urandom), 28'($urandom), 1'b0, 60, k1, k2, kl);
    end

`ifdef DES_KEY_DECRYPT_EN
    applyStimulus(FIPS_C, FIPS_D, 1'b1, 100, k1, k2, kl);
    checkOutput("dec_first", k1, 48'hCB3D8B0E17F5);
    checkOutput("dec_second", k2, refSubkey(FIPS_C, FIPS_D, 14));
    checkOutput("dec_last", kl, 48'h1B02EFFC7072);
    for (int t = 0; t < 3; t++) begin
      applyStimulus(28'($urandom), 28'($urandom), 1'b1, 60, k1, k2, kl);
    end
    applyStimulus(FIPS_C, FIPS_D, 1'b0, 100, k1, k2, kl);
    checkOutput("enc_after_dec_k1", k1, 48'h1B02EFFC7072);
`endif

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
